// File: rtl/sram_port_arbiter_if.sv
// Bundle of signals between the fetch, data and DMA requesters, the arbiter and the SRAM macro.
// The master side is the requesters plus the macro; the slave side is the arbiter.
interface sram_port_arbiter_if #(
   parameter int CNT_W = 16
);
   logic             if_req;
   logic [31:0]      if_addr;
   logic             if_ready;
   logic [31:0]      if_rdata;

   logic             d_req;
   logic             d_wen;
   logic [3:0]       d_ben;
   logic [31:0]      d_addr;
   logic [31:0]      d_din;
   logic [31:0]      d_dout;

   logic             dma_req;
   logic             dma_we;
   logic [3:0]       dma_ben;
   logic [31:0]      dma_addr;
   logic [31:0]      dma_wdata;
   logic             dma_gnt;
   logic             dma_rvalid;
   logic [31:0]      dma_rdata;

   logic             m_cen;
   logic             m_wen;
   logic [3:0]       m_ben;
   logic [31:0]      m_addr;
   logic [31:0]      m_din;
   logic [31:0]      m_dout;

   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output if_req, if_addr, d_req, d_wen, d_ben, d_addr, d_din,
             dma_req, dma_we, dma_ben, dma_addr, dma_wdata, m_dout,
      input  if_ready, if_rdata, d_dout, dma_gnt, dma_rvalid, dma_rdata,
             m_cen, m_wen, m_ben, m_addr, m_din, stall_cnt
   );

   modport slave (
      input  if_req, if_addr, d_req, d_wen, d_ben, d_addr, d_din,
             dma_req, dma_we, dma_ben, dma_addr, dma_wdata, m_dout,
      output if_ready, if_rdata, d_dout, dma_gnt, dma_rvalid, dma_rdata,
             m_cen, m_wen, m_ben, m_addr, m_din, stall_cnt
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: data > starved DMA > fetch > DMA, combinational grant, 1-cycle read return.
// Define SRAM_ARB_DMA_EN to build the DMA port and its starvation counter.
module sram_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sram_port_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_DATA,
      OWN_DMA
   } owner_e;

   owner_e           owner_q, owner_d;
   logic             rd_q, rd_d;
   logic [31:0]      if_rdata_q, if_rdata_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic             gnt_data, gnt_fetch, gnt_dma;
   logic             if_ready;

`ifdef SRAM_ARB_DMA_EN
   logic [3:0] deny_q, deny_d;
   logic       starved;

   assign starved = (deny_q == 4'(STARVE_LIMIT));

   // Grants are gated by reset so nothing reaches the macro while rst_n is low.
   always_comb begin
      gnt_data  = rst_n && bus.d_req;
      gnt_dma   = rst_n && !bus.d_req && bus.dma_req && (starved || !bus.if_req);
      gnt_fetch = rst_n && !bus.d_req && bus.if_req && !(bus.dma_req && starved);

      deny_d = deny_q;
      if (!bus.dma_req || gnt_dma) begin
         deny_d = '0;
      end else if (!starved) begin
         deny_d = deny_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         deny_q <= '0;
      end else begin
         deny_q <= deny_d;
      end
   end

   assign bus.dma_gnt    = gnt_dma;
   assign bus.dma_rvalid = rst_n && (owner_q == OWN_DMA) && rd_q;
   assign bus.dma_rdata  = bus.m_dout;
`else
   assign gnt_data  = rst_n && bus.d_req;
   assign gnt_fetch = rst_n && !bus.d_req && bus.if_req;
   assign gnt_dma   = 1'b0;

   assign bus.dma_gnt    = 1'b0;
   assign bus.dma_rvalid = 1'b0;
   assign bus.dma_rdata  = '0;
`endif

   // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      owner_d    = OWN_NONE;
      rd_d       = 1'b0;
      bus.m_cen  = 1'b1;
      bus.m_wen  = 1'b1;
      bus.m_ben  = 4'hF;
      bus.m_addr = '0;
      bus.m_din  = '0;

      if (gnt_data) begin
         owner_d    = OWN_DATA;
         rd_d       = bus.d_wen;
         bus.m_cen  = 1'b0;
         bus.m_wen  = bus.d_wen;
         bus.m_ben  = bus.d_ben;
         bus.m_addr = bus.d_addr;
         bus.m_din  = bus.d_din;
      end else if (gnt_dma) begin
         owner_d    = OWN_DMA;
         rd_d       = !bus.dma_we;
         bus.m_cen  = 1'b0;
         bus.m_wen  = !bus.dma_we;
         bus.m_ben  = ~bus.dma_ben;
         bus.m_addr = bus.dma_addr;
         bus.m_din  = bus.dma_wdata;
      end else if (gnt_fetch) begin
         owner_d    = OWN_FETCH;
         rd_d       = 1'b1;
         bus.m_cen  = 1'b0;
         bus.m_ben  = 4'h0;
         bus.m_addr = bus.if_addr;
      end

      stall_d = stall_q;
      if (bus.if_req && !gnt_fetch && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end

      // The read in flight is dropped if reset lands between grant and return.
      if_ready   = rst_n && (owner_q == OWN_FETCH) && rd_q;
      if_rdata_d = if_ready ? bus.m_dout : if_rdata_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q    <= OWN_NONE;
         rd_q       <= 1'b0;
         if_rdata_q <= '0;
         stall_q    <= '0;
      end else begin
         owner_q    <= owner_d;
         rd_q       <= rd_d;
         if_rdata_q <= if_rdata_d;
         stall_q    <= stall_d;
      end
   end

   assign bus.if_ready  = if_ready;
   assign bus.if_rdata  = rst_n ? if_rdata_d : '0;
   assign bus.d_dout    = bus.m_dout;
   assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter; DMA scenarios run when SRAM_ARB_DMA_EN is defined.
// A second instance with a 2-bit stall counter exercises counter saturation.
module tb_sram_port_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   sram_port_arbiter_if #(.CNT_W(16)) bus ();
   sram_port_arbiter_if #(.CNT_W(2))  bus2 ();

   sram_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   sram_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(2)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_m_cen"},  32'(bus.m_cen), 32'h1);
      check({tag, "_m_wen"},  32'(bus.m_wen), 32'h1);
      check({tag, "_m_ben"},  32'(bus.m_ben), 32'hF);
      check({tag, "_if_rdy"}, 32'(bus.if_ready), 32'h0);
      check({tag, "_dma_gnt"}, 32'(bus.dma_gnt), 32'h0);
      check({tag, "_dma_rv"}, 32'(bus.dma_rvalid), 32'h0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      bus.if_req = 0; bus.if_addr = 0;
      bus.d_req = 0; bus.d_wen = 1; bus.d_ben = 4'hF; bus.d_addr = 0; bus.d_din = 0;
      bus.dma_req = 0; bus.dma_we = 0; bus.dma_ben = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
      bus.m_dout = 0;
      bus2.if_req = 0; bus2.if_addr = 0;
      bus2.d_req = 0; bus2.d_wen = 1; bus2.d_ben = 4'hF; bus2.d_addr = 0; bus2.d_din = 0;
      bus2.dma_req = 0; bus2.dma_we = 0; bus2.dma_ben = 0; bus2.dma_addr = 0; bus2.dma_wdata = 0;
      bus2.m_dout = 0;

      // Reset state
      cyc();
      cyc();
      check_idle_outputs("rst");
      check("rst_stall", 32'(bus.stall_cnt), 32'h0);
      check("rst_if_rdata", bus.if_rdata, 32'h0);

      // Plain fetch, data returns next cycle, then held
      rst_n = 1'b1;
      bus.if_req = 1; bus.if_addr = 32'h100;
      #1;
      check("f_m_cen", 32'(bus.m_cen), 32'h0);
      check("f_m_addr", bus.m_addr, 32'h100);
      check("f_m_wen", 32'(bus.m_wen), 32'h1);
      cyc();
      bus.if_req = 0; bus.m_dout = 32'h13;
      #1;
      check("f_if_ready", 32'(bus.if_ready), 32'h1);
      check("f_if_rdata", bus.if_rdata, 32'h13);
      check("f_stall", 32'(bus.stall_cnt), 32'h0);
      check("f_idle_cen", 32'(bus.m_cen), 32'h1);
      cyc();
      bus.m_dout = 32'h55;
      #1;
      check("f_ready_drop", 32'(bus.if_ready), 32'h0);
      check("f_rdata_hold", bus.if_rdata, 32'h13);

      // Data read beats fetch in the same cycle
      bus.if_req = 1; bus.if_addr = 32'h300;
      bus.d_req = 1; bus.d_wen = 1; bus.d_addr = 32'h2000; bus.d_ben = 4'h0;
      #1;
      check("df_m_addr", bus.m_addr, 32'h2000);
      check("df_m_wen", 32'(bus.m_wen), 32'h1);
      cyc();
      bus.if_req = 0; bus.d_req = 0; bus.m_dout = 32'hCAFE0001;
      #1;
      check("df_if_ready", 32'(bus.if_ready), 32'h0);
      check("df_stall", 32'(bus.stall_cnt), 32'h1);
      check("df_d_dout", bus.d_dout, 32'hCAFE0001);

      // Data write
      bus.d_req = 1; bus.d_wen = 0; bus.d_ben = 4'b1010; bus.d_addr = 32'h40; bus.d_din = 32'h12345678;
      #1;
      check("dw_m_wen", 32'(bus.m_wen), 32'h0);
      check("dw_m_ben", 32'(bus.m_ben), 32'hA);
      check("dw_m_din", bus.m_din, 32'h12345678);
      check("dw_m_addr", bus.m_addr, 32'h40);

      // Data read followed directly by a fetch, no bubble
      cyc();
      bus.d_wen = 1; bus.d_addr = 32'h80; bus.d_ben = 4'h0;
      #1;
      check("bb_if_ready0", 32'(bus.if_ready), 32'h0);
      check("bb_d_addr", bus.m_addr, 32'h80);
      cyc();
      bus.d_req = 0; bus.if_req = 1; bus.if_addr = 32'h104; bus.m_dout = 32'hAAAA0001;
      #1;
      check("bb_d_dout", bus.d_dout, 32'hAAAA0001);
      check("bb_f_addr", bus.m_addr, 32'h104);
      check("bb_f_cen", 32'(bus.m_cen), 32'h0);
      cyc();
      bus.if_req = 0; bus.m_dout = 32'hBBBB0002;
      #1;
      check("bb_if_ready", 32'(bus.if_ready), 32'h1);
      check("bb_if_rdata", bus.if_rdata, 32'hBBBB0002);

      // Fetch granted, then reset before the data returns
      bus.if_req = 1; bus.if_addr = 32'h108;
      cyc();
      bus.if_req = 0; rst_n = 0; bus.m_dout = 32'h77;
      #1;
      check_idle_outputs("frst");
      check("frst_if_rdata", bus.if_rdata, 32'h0);
      cyc();
      cyc();
      rst_n = 1;
      #1;
      check("frst_rel_ready", 32'(bus.if_ready), 32'h0);
      check("frst_rel_stall", 32'(bus.stall_cnt), 32'h0);
      check("frst_rel_rdata", bus.if_rdata, 32'h0);

`ifdef SRAM_ARB_DMA_EN
      // DMA held against continuous fetch: wins on cycle 5
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_ben = 4'hF; bus.dma_addr = 32'h9000;
      bus.if_req = 1; bus.if_addr = 32'h200;
      for (int i = 1; i <= 5; i++) begin
         #1;
         check($sformatf("st_gnt_c%0d", i), 32'(bus.dma_gnt), (i == 5) ? 32'h1 : 32'h0);
         check($sformatf("st_addr_c%0d", i), bus.m_addr, (i == 5) ? 32'h9000 : 32'h200);
         cyc();
      end
      bus.dma_req = 0; bus.if_req = 0; bus.m_dout = 32'h5A5A;
      #1;
      check("st_rvalid", 32'(bus.dma_rvalid), 32'h1);
      check("st_rdata", bus.dma_rdata, 32'h5A5A);
      check("st_if_ready", 32'(bus.if_ready), 32'h0);
      check("st_stall", 32'(bus.stall_cnt), 32'h1);

      // DMA write: enables inverted, no read return
      bus.dma_req = 1; bus.dma_we = 1; bus.dma_ben = 4'b0011;
      bus.dma_wdata = 32'hDEADBEEF; bus.dma_addr = 32'h9004;
      #1;
      check("dw_gnt", 32'(bus.dma_gnt), 32'h1);
      check("dma_w_wen", 32'(bus.m_wen), 32'h0);
      check("dma_w_ben", 32'(bus.m_ben), 32'hC);
      check("dma_w_din", bus.m_din, 32'hDEADBEEF);
      cyc();
      bus.dma_req = 0;
      #1;
      check("dma_w_norv", 32'(bus.dma_rvalid), 32'h0);

      // Starved DMA yields to data, then wins the first data-free cycle
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h9008;
      bus.if_req = 1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         check($sformatf("sd_gnt_c%0d", i), 32'(bus.dma_gnt), 32'h0);
         cyc();
      end
      bus.d_req = 1; bus.d_wen = 1; bus.d_addr = 32'h3000;
      #1;
      check("sd_data_gnt", 32'(bus.dma_gnt), 32'h0);
      check("sd_data_addr", bus.m_addr, 32'h3000);
      cyc();
      bus.d_req = 0;
      #1;
      check("sd_dma_gnt", 32'(bus.dma_gnt), 32'h1);
      check("sd_dma_addr", bus.m_addr, 32'h9008);
      cyc();
      bus.if_req = 0;

      // Granted DMA read, then reset for two cycles
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h900C;
      #1;
      check("dr_gnt", 32'(bus.dma_gnt), 32'h1);
      cyc();
      rst_n = 0; bus.m_dout = 32'h1234;
      #1;
      check_idle_outputs("drst1");
      cyc();
      check_idle_outputs("drst2");
      cyc();
      rst_n = 1; bus.dma_req = 0;
      #1;
      check("drst_rel_rv", 32'(bus.dma_rvalid), 32'h0);
      check("drst_rel_ready", 32'(bus.if_ready), 32'h0);
      check("drst_rel_stall", 32'(bus.stall_cnt), 32'h0);
      check("drst_rel_rdata", bus.if_rdata, 32'h0);
`else
      // DMA absent: requests ignored, fetch gets every data-free cycle
      bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h9000;
      bus.if_req = 1; bus.if_addr = 32'h500;
      bus.d_wen = 1; bus.d_addr = 32'h4000;
      for (int i = 0; i < 20; i++) begin
         bus.d_req = (i % 4 == 3);
         #1;
         check($sformatf("nd_gnt_c%0d", i), 32'(bus.dma_gnt), 32'h0);
         check($sformatf("nd_addr_c%0d", i), bus.m_addr, (i % 4 == 3) ? 32'h4000 : 32'h500);
         check($sformatf("nd_rv_c%0d", i), 32'(bus.dma_rvalid), 32'h0);
         cyc();
      end
      bus.dma_req = 0; bus.if_req = 0; bus.d_req = 0;
      #1;
      check("nd_stall", 32'(bus.stall_cnt), 32'h5);
`endif

      // Stall counter saturation on the 2-bit instance
      bus2.if_req = 1; bus2.d_req = 1;
      cyc();
      cyc();
      check("sat_stall_2", 32'(bus2.stall_cnt), 32'h2);
      cyc();
      cyc();
      cyc();
      check("sat_stall_max", 32'(bus2.stall_cnt), 32'h3);
      bus2.if_req = 0; bus2.d_req = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
